fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Upstream neighbour of instructionMemory: owns the program counter and drives the combinational
//  instruction memory address. Captures each returned word with its PC into a 2-entry fetch FIFO and
//  presents it to decode over a valid/ready handshake.
//  Accepts redirects (branch/jal/jalr) from execute, flushing stale fetches. Raises a sticky fault on
//  a misaligned or out-of-range PC.
// PARAMETERS
//  RESET_PC      32'h0000_0000  PC loaded on reset
//  IMEM_MAX_ADDR 32'd52         highest valid word-aligned byte address in instruction memory
// PORTS
//  clk              in   1   system clock, rising edge
//  rst_n            in   1   asynchronous reset, active low
//  imem_addr        out  32  byte address to instruction memory (A)
//  imem_rd          in   32  instruction word from memory (RD), valid in the same cycle
//  redirect_valid   in   1   execute requests PC change this cycle
//  redirect_target  in   32  new PC when redirect_valid=1
//  out_valid        out  1   FIFO head valid
//  out_ready        in   1   decode accepts head this cycle
//  out_instr        out  32  head instruction word
//  out_pc           out  32  head PC
//  out_pc_plus4     out  32  head PC+4 (mod 2^32), for jal/jalr link
//  fault            out  1   sticky fetch fault
//  fault_addr       out  32  PC that caused the fault
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-stream): pc=RESET_PC, FIFO empty, state=BOOT, out_valid=0,
//    out_instr/out_pc=0, out_pc_plus4=4, fault=0, fault_addr=0. In-flight redirects are dropped.
//  - imem_addr = pc at all times (combinational from pc register).
//  - FSM:
//    BOOT  : one cycle, no push, -> RUN.
//    RUN   : fetch when FIFO not full. push {imem_rd, pc}; pc <= pc+4.
//            Fetch decision uses registered FIFO count only; no combinational out_ready->pc path.
//    FAULT : no pushes, pc frozen. Exit only by reset.
//  - Handshake: pop on out_valid&&out_ready. Head fields stable while out_valid&&!out_ready.
//    Simultaneous push and pop with FIFO full is not a fetch (count-based). Push+pop at count=1 keeps
//    count=1. Entries leave strictly in fetch order.
//  - Latency: first out_valid on the 2nd rising clk edge after rst_n rises.
//    Steady state with out_ready=1: one instruction per cycle.
//  - Redirect (RUN):
//    * Flush all FIFO entries (a concurrent pop still counts as accepted). pc <= redirect_target.
//    * No push that cycle. out_valid=0 the following cycle. Target word appears at head 1 cycle later.
//    * Redirect overrides the sequential pc+4 update.
//    * Redirect in BOOT: target loaded, state -> RUN. Redirect in FAULT: ignored.
//  - Fault: in RUN, if pc[1:0]!=0 or pc>IMEM_MAX_ADDR at a would-be fetch:
//    no push, fault<=1, fault_addr<=pc, state->FAULT.
//    Entries already in the FIFO still drain normally.
//  - Arithmetic: pc+4 is 32-bit unsigned, wraps mod 2^32. The range check catches wrap before use.
// STRUCTURE
//  - Shared package: FSM state encoding (BOOT/RUN/FAULT), NOP/reset instruction constant, PC width,
//    IMEM_MAX_ADDR default.
//  - One sub-module: fetch_fifo.
//    * 2-deep, 64-bit payload {instr,pc}, registered count, synchronous flush, async active-low reset.
//  - Top: pc register, FSM, fault logic.
// TESTING
//  1. Reset release, out_ready=1 -> edge 2: out_valid=1, out_pc=0, out_instr=0x007302B3.
//     Next cycles: pc 4 (0x407302B3), 8 (0xFFC4A303), one per cycle.
//  2. out_ready=0 for 6 cycles from reset -> FIFO holds pc 0,4; imem_addr stays 8; fault=0.
//     out_ready=1 -> pcs 0,4,8,12 in order, no loss or duplicates.
//  3. FIFO full (pc 0,4), redirect_valid=1 with target 0x24 -> next cycle out_valid=0.
//     Then out_pc=0x24, out_instr=0x0062E233, out_pc_plus4=0x28.
//  4. Redirect target 0x22 -> fault=1, fault_addr=0x22, no further out_valid after drain.
//     Later redirect to 0x0 is ignored.
//  5. Free-run from 0 -> pc 0..52 delivered (14 words), then fault=1, fault_addr=56, imem_addr holds 56.
//  6. Drop rst_n mid-stream with out_valid=1 and 2 entries buffered.
//     -> out_valid, fault, count=0 immediately (asynchronously).
//     After release the stream restarts at pc 0 as in test 1.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: state encoding, widths, reset constants
// and the PC legality check used before every fetch.
package fetch_unit_pkg;

    localparam int PC_W = 32;
    localparam int ENTRY_W = 2 * PC_W;
    localparam logic [PC_W-1:0] RESET_INSTR = 32'h0000_0000;
    localparam logic [PC_W-1:0] IMEM_MAX_ADDR_DEFAULT = 32'd52;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    // A PC is unusable if it is not word aligned or lies past the last memory word;
    // the range check also rejects any address produced by pc+4 wrapping.
    function automatic logic pc_is_bad(input logic [PC_W-1:0] pc,
                                       input logic [PC_W-1:0] max_addr);
        return (pc[1:0] != 2'b00) || (pc > max_addr);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order buffer of {instr, pc}; head is always slot 0 so the
// outputs come straight from registers.
module fetch_fifo
    import fetch_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               push,
    input  logic [ENTRY_W-1:0] din,
    input  logic               ready,
    output logic               valid,
    output logic [ENTRY_W-1:0] dout,
    output logic [1:0]         count
);

    logic [ENTRY_W-1:0] entry0_r;
    logic [ENTRY_W-1:0] entry1_r;
    logic [1:0]         count_r;
    logic               pop_s;

    assign valid = (count_r != 2'd0);
    assign pop_s = valid && ready;
    assign dout  = entry0_r;
    assign count = count_r;

    // Storage and occupancy; flush wins over any concurrent push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0_r <= {ENTRY_W{1'b0}};
            entry1_r <= {ENTRY_W{1'b0}};
            count_r  <= 2'd0;
        end else if (flush) begin
            count_r <= 2'd0;
        end else begin
            case ({push, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        entry0_r <= din;
                        count_r  <= 2'd1;
                    end else if (count_r == 2'd1) begin
                        entry1_r <= din;
                        count_r  <= 2'd2;
                    end
                end
                2'b01: begin
                    entry0_r <= entry1_r;
                    count_r  <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        entry0_r <= din;
                    end else begin
                        entry0_r <= entry1_r;
                        entry1_r <= din;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Program counter, BOOT/RUN/FAULT control and sticky fault capture in front of
// a combinational instruction memory; fetched words are queued in fetch_fifo.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC      = 32'h0000_0000,
    parameter logic [PC_W-1:0] IMEM_MAX_ADDR = IMEM_MAX_ADDR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] imem_addr,
    input  logic [PC_W-1:0] imem_rd,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic [PC_W-1:0] out_pc_plus4,
    output logic            fault,
    output logic [PC_W-1:0] fault_addr
);

    fetch_state_e       state_r;
    fetch_state_e       state_nxt_s;
    logic [PC_W-1:0]    pc_r;
    logic [PC_W-1:0]    pc_nxt_s;
    logic               fault_r;
    logic [PC_W-1:0]    fault_addr_r;
    logic               push_s;
    logic               flush_s;
    logic               fault_set_s;
    logic               can_fetch_s;
    logic [1:0]         count_s;
    logic [ENTRY_W-1:0] head_s;

    // Fetch decision looks only at the registered occupancy, never at out_ready.
    assign can_fetch_s = (count_s != 2'd2);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_BOOT: state_nxt_s = ST_RUN;
            ST_RUN: begin
                if (!redirect_valid && can_fetch_s && pc_is_bad(pc_r, IMEM_MAX_ADDR)) begin
                    state_nxt_s = ST_FAULT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FAULT: state_nxt_s = ST_FAULT;
            default:  state_nxt_s = ST_BOOT;
        endcase
    end

    // FSM outputs: push/flush strobes, next PC and fault capture.
    always_comb begin
        push_s      = 1'b0;
        flush_s     = 1'b0;
        fault_set_s = 1'b0;
        pc_nxt_s    = pc_r;
        case (state_r)
            ST_BOOT: begin
                if (redirect_valid) begin
                    pc_nxt_s = redirect_target;
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    flush_s  = 1'b1;
                    pc_nxt_s = redirect_target;
                end else if (can_fetch_s) begin
                    if (pc_is_bad(pc_r, IMEM_MAX_ADDR)) begin
                        fault_set_s = 1'b1;
                    end else begin
                        push_s   = 1'b1;
                        pc_nxt_s = pc_r + 32'd4;
                    end
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            ST_FAULT: pc_nxt_s = pc_r;
            default:  pc_nxt_s = pc_r;
        endcase
    end

    // PC and sticky fault registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r         <= RESET_PC;
            fault_r      <= 1'b0;
            fault_addr_r <= 32'h0000_0000;
        end else begin
            pc_r <= pc_nxt_s;
            if (fault_set_s) begin
                fault_r      <= 1'b1;
                fault_addr_r <= pc_r;
            end
        end
    end

    fetch_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush_s),
        .push  (push_s),
        .din   ({imem_rd, pc_r}),
        .ready (out_ready),
        .valid (out_valid),
        .dout  (head_s),
        .count (count_s)
    );

    assign imem_addr    = pc_r;
    assign out_instr    = head_s[ENTRY_W-1:PC_W];
    assign out_pc       = head_s[PC_W-1:0];
    assign out_pc_plus4 = out_pc + 32'd4;
    assign fault        = fault_r;
    assign fault_addr   = fault_addr_r;

    logic unused_s;
    assign unused_s = ^{RESET_INSTR};

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a bench-side instruction ROM and a queue of
// expected fetch PCs checked on every accepted handshake.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        fault;
    logic [31:0] fault_addr;

    logic [31:0] rom [0:15];
    logic [31:0] exp_q [$];
    int          tests;
    int          fails;

    fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_addr       (imem_addr),
        .imem_rd         (imem_rd),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .out_pc_plus4    (out_pc_plus4),
        .fault           (fault),
        .fault_addr      (fault_addr)
    );

    assign imem_rd = (imem_addr <= 32'd52 && imem_addr[1:0] == 2'b00) ? rom[imem_addr[5:2]]
                                                                       : 32'h0000_0013;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: sample the handshake just before the edge, then step past it.
    task automatic tick();
        logic        hs;
        logic [31:0] hpc;
        logic [31:0] hinstr;
        logic [31:0] epc;
        #4;
        hs     = out_valid && out_ready;
        hpc    = out_pc;
        hinstr = out_instr;
        if (hs) begin
            check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                epc = exp_q.pop_front();
                check("sb_pc", hpc, epc);
                check("sb_instr", hinstr, rom[epc[5:2]]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        check("sb_drain", exp_q.size(), 32'd0);
        exp_q.delete();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = ready;
        tick();
        tick();
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rom[0]  = 32'h007302B3; rom[1]  = 32'h407302B3; rom[2]  = 32'hFFC4A303;
        rom[3]  = 32'h00A00093; rom[4]  = 32'h00100113; rom[5]  = 32'h002081B3;
        rom[6]  = 32'h40208233; rom[7]  = 32'h0020F2B3; rom[8]  = 32'h0020E333;
        rom[9]  = 32'h0062E233; rom[10] = 32'h00C0006F; rom[11] = 32'hFE209EE3;
        rom[12] = 32'h00008067; rom[13] = 32'h00000013; rom[14] = 32'h0;
        rom[15] = 32'h0;
        rst_n           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        out_ready       = 1'b0;
        #1;
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_instr", out_instr, 32'h0);
        check("reset_pc", out_pc, 32'h0);
        check("reset_pc4", out_pc_plus4, 32'h4);
        check("reset_fault", {31'd0, fault}, 32'd0);
        check("reset_faddr", fault_addr, 32'h0);
        check("reset_addr", imem_addr, 32'h0);

        // Test 1: first word on the second edge, then one per cycle.
        do_reset(1'b1);
        tick();
        check("t1_edge1_valid", {31'd0, out_valid}, 32'd0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        tick();
        check("t1_edge2_valid", {31'd0, out_valid}, 32'd1);
        check("t1_edge2_pc", out_pc, 32'h0);
        check("t1_edge2_instr", out_instr, 32'h007302B3);
        check("t1_edge2_pc4", out_pc_plus4, 32'h4);
        tick();
        check("t1_edge3_pc", out_pc, 32'h4);
        check("t1_edge3_instr", out_instr, 32'h407302B3);
        tick();
        check("t1_edge4_pc", out_pc, 32'h8);
        check("t1_edge4_instr", out_instr, 32'hFFC4A303);
        tick();
        tick();
        out_ready = 1'b0;

        // Test 2: back-pressure fills the FIFO, then drains in order.
        do_reset(1'b0);
        repeat (6) tick();
        check("t2_valid", {31'd0, out_valid}, 32'd1);
        check("t2_head", out_pc, 32'h0);
        check("t2_addr", imem_addr, 32'h8);
        check("t2_fault", {31'd0, fault}, 32'd0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;

        // Test 3: redirect with a full FIFO.
        do_reset(1'b0);
        repeat (4) tick();
        check("t3_full_valid", {31'd0, out_valid}, 32'd1);
        redirect_valid  = 1'b1;
        redirect_target = 32'h24;
        tick();
        redirect_valid = 1'b0;
        check("t3_flush_valid", {31'd0, out_valid}, 32'd0);
        check("t3_addr", imem_addr, 32'h24);
        tick();
        check("t3_tgt_valid", {31'd0, out_valid}, 32'd1);
        check("t3_tgt_pc", out_pc, 32'h24);
        check("t3_tgt_instr", out_instr, 32'h0062E233);
        check("t3_tgt_pc4", out_pc_plus4, 32'h28);
        tick();
        tick();
        check("t3_stable_pc", out_pc, 32'h24);
        check("t3_stable_instr", out_instr, 32'h0062E233);

        // Test 4: misaligned redirect target faults; later redirect ignored.
        do_reset(1'b0);
        tick();
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h22;
        tick();
        redirect_valid = 1'b0;
        check("t4_flush_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("t4_fault", {31'd0, fault}, 32'd1);
        check("t4_faddr", fault_addr, 32'h22);
        check("t4_valid", {31'd0, out_valid}, 32'd0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        check("t4_ign_addr", imem_addr, 32'h22);
        check("t4_ign_fault", {31'd0, fault}, 32'd1);
        check("t4_ign_faddr", fault_addr, 32'h22);
        check("t4_ign_valid", {31'd0, out_valid}, 32'd0);

        // Test 5: free run to the end of memory.
        do_reset(1'b1);
        for (int a = 0; a <= 52; a += 4) exp_q.push_back(a[31:0]);
        repeat (20) tick();
        out_ready = 1'b0;
        check("t5_count", exp_q.size(), 32'd0);
        check("t5_fault", {31'd0, fault}, 32'd1);
        check("t5_faddr", fault_addr, 32'd56);
        check("t5_addr", imem_addr, 32'd56);
        check("t5_valid", {31'd0, out_valid}, 32'd0);

        // Test 6: asynchronous reset mid-stream, then restart.
        do_reset(1'b0);
        repeat (4) tick();
        check("t6_pre_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", {31'd0, out_valid}, 32'd0);
        check("t6_async_fault", {31'd0, fault}, 32'd0);
        check("t6_async_pc", out_pc, 32'h0);
        check("t6_async_addr", imem_addr, 32'h0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        tick();
        check("t6_edge1_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("t6_edge2_valid", {31'd0, out_valid}, 32'd1);
        check("t6_edge2_pc", out_pc, 32'h0);
        check("t6_edge2_instr", out_instr, 32'h007302B3);
        repeat (3) tick();
        out_ready = 1'b0;
        check("t6_drain", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
